// File: rtl/ex_mem_buffer.sv
// rtl/ex_mem_buffer.sv - EX->MEM pipeline register with a 2-entry skid buffer
//
// Captures the ALU result, zero flag, store data and the MEM/WB control bundle
// of each instruction leaving EX and presents them to MEM (and to the EX->EX
// forwarding path through out_y). A two-entry skid buffer gives a registered
// in_ready while still sustaining one instruction per cycle.
//
// Parameters:
//   DATA_W     width of ALU result and store data
//   REGADDR_W  width of destination register index
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   flush                       synchronous squash of all buffered entries
//   in_valid / in_ready         EX-side handshake
//   alu_y, alu_zero,            ALU result and flags
//   alu_overflow
//   write_data, wb_reg,         store data, destination register and
//   reg_write, mem_read,        MEM/WB control bundle of the instruction
//   mem_write
//   out_valid / out_ready       MEM-side handshake (head entry)
//   out_y .. out_mem_write      head entry fields
//   out_exc_ov                  head entry carries an overflow exception
//
// Configuration:
//   EX_MEM_OVF_TRAP_EN  when defined, an entry accepted with alu_overflow = 1
//                       is stored with its reg_write/mem_read/mem_write bits
//                       cleared and out_exc_ov set. When undefined,
//                       alu_overflow is ignored and out_exc_ov is 0.

module ex_mem_buffer #(
    parameter int DATA_W    = 32,
    parameter int REGADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,

    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    alu_y,
    input  logic                 alu_zero,
    input  logic                 alu_overflow,
    input  logic [DATA_W-1:0]    write_data,
    input  logic [REGADDR_W-1:0] wb_reg,
    input  logic                 reg_write,
    input  logic                 mem_read,
    input  logic                 mem_write,

    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_y,
    output logic                 out_zero,
    output logic [DATA_W-1:0]    out_write_data,
    output logic [REGADDR_W-1:0] out_wb_reg,
    output logic                 out_reg_write,
    output logic                 out_mem_read,
    output logic                 out_mem_write,
    output logic                 out_exc_ov
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0]    y;
        logic                 zero;
        logic [DATA_W-1:0]    wdata;
        logic [REGADDR_W-1:0] wb_reg;
        logic                 reg_write;
        logic                 mem_read;
        logic                 mem_write;
        logic                 exc_ov;
    } entry_t;

    localparam entry_t ENTRY_ZERO = '0;

    state_t state;
    entry_t head;
    entry_t skid;
    entry_t in_entry;

    logic acc;
    logic deq;

    // Entry formation: the overflow trap only rewrites the control bits, the
    // data fields are always stored unchanged.
`ifdef EX_MEM_OVF_TRAP_EN
    always_comb begin
        in_entry           = ENTRY_ZERO;
        in_entry.y         = alu_y;
        in_entry.zero      = alu_zero;
        in_entry.wdata     = write_data;
        in_entry.wb_reg    = wb_reg;
        in_entry.reg_write = reg_write & ~alu_overflow;
        in_entry.mem_read  = mem_read & ~alu_overflow;
        in_entry.mem_write = mem_write & ~alu_overflow;
        in_entry.exc_ov    = alu_overflow;
    end
`else
    logic unused_alu_overflow;
    assign unused_alu_overflow = alu_overflow;

    always_comb begin
        in_entry           = ENTRY_ZERO;
        in_entry.y         = alu_y;
        in_entry.zero      = alu_zero;
        in_entry.wdata     = write_data;
        in_entry.wb_reg    = wb_reg;
        in_entry.reg_write = reg_write;
        in_entry.mem_read  = mem_read;
        in_entry.mem_write = mem_write;
        in_entry.exc_ov    = 1'b0;
    end
`endif

    // in_ready is low while reset is held so EX never sees a handshake that
    // the reset is about to discard.
    assign in_ready  = ~rst & (state != S_TWO);
    assign out_valid = (state != S_EMPTY);

    assign acc = in_valid & in_ready;
    assign deq = out_valid & out_ready;

    // Whenever the head slot becomes empty it is cleared, so a bubble on the
    // MEM side always carries zero control bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_EMPTY;
            head  <= ENTRY_ZERO;
            skid  <= ENTRY_ZERO;
        end else if (flush) begin
            state <= S_EMPTY;
            head  <= ENTRY_ZERO;
            skid  <= ENTRY_ZERO;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (acc) begin
                        head  <= in_entry;
                        state <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (acc && !deq) begin
                        skid  <= in_entry;
                        state <= S_TWO;
                    end else if (!acc && deq) begin
                        head  <= ENTRY_ZERO;
                        state <= S_EMPTY;
                    end else if (acc && deq) begin
                        // Head is consumed this cycle; the new entry replaces
                        // it directly and the skid slot stays unused.
                        head <= in_entry;
                    end
                end
                S_TWO: begin
                    if (deq) begin
                        head  <= skid;
                        skid  <= ENTRY_ZERO;
                        state <= S_ONE;
                    end
                end
                default: begin
                    state <= S_EMPTY;
                    head  <= ENTRY_ZERO;
                    skid  <= ENTRY_ZERO;
                end
            endcase
        end
    end

    assign out_y          = head.y;
    assign out_zero       = head.zero;
    assign out_write_data = head.wdata;
    assign out_wb_reg     = head.wb_reg;
    assign out_reg_write  = head.reg_write;
    assign out_mem_read   = head.mem_read;
    assign out_mem_write  = head.mem_write;
    assign out_exc_ov     = head.exc_ov;

endmodule

// File: tb/tb_ex_mem_buffer.sv
// tb/tb_ex_mem_buffer.sv - scoreboard bench for ex_mem_buffer

module tb_ex_mem_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_y;
    logic        alu_zero;
    logic        alu_overflow;
    logic [31:0] write_data;
    logic [4:0]  wb_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic        out_zero;
    logic [31:0] out_write_data;
    logic [4:0]  out_wb_reg;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_exc_ov;

    ex_mem_buffer #(.DATA_W(32), .REGADDR_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_y          (alu_y),
        .alu_zero       (alu_zero),
        .alu_overflow   (alu_overflow),
        .write_data     (write_data),
        .wb_reg         (wb_reg),
        .reg_write      (reg_write),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_y          (out_y),
        .out_zero       (out_zero),
        .out_write_data (out_write_data),
        .out_wb_reg     (out_wb_reg),
        .out_reg_write  (out_reg_write),
        .out_mem_read   (out_mem_read),
        .out_mem_write  (out_mem_write),
        .out_exc_ov     (out_exc_ov)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] y;
        logic        z;
        logic        ov;
        logic [31:0] wd;
        logic [4:0]  wr;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        ordy;
        logic        fl;
        logic        r;
    } stim_t;

    typedef struct packed {
        logic [31:0] y;
        logic        z;
        logic [31:0] wd;
        logic [4:0]  wr;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        exc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: what MEM should see for an accepted instruction.
    function automatic exp_t model(input stim_t s);
        exp_t e;
        e.y  = s.y;
        e.z  = s.z;
        e.wd = s.wd;
        e.wr = s.wr;
`ifdef EX_MEM_OVF_TRAP_EN
        e.rw  = s.ov ? 1'b0 : s.rw;
        e.mr  = s.ov ? 1'b0 : s.mr;
        e.mw  = s.ov ? 1'b0 : s.mw;
        e.exc = s.ov;
`else
        e.rw  = s.rw;
        e.mr  = s.mr;
        e.mw  = s.mw;
        e.exc = 1'b0;
`endif
        return e;
    endfunction

    function automatic stim_t idle(input logic ordy);
        stim_t s;
        s      = '0;
        s.ordy = ordy;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.v    = ($urandom_range(0, 3) != 0);
        s.y    = $urandom;
        s.z    = 1'($urandom_range(0, 1));
        s.ov   = ($urandom_range(0, 3) == 0);
        s.wd   = $urandom;
        s.wr   = 5'($urandom_range(0, 31));
        s.rw   = 1'($urandom_range(0, 1));
        s.mr   = 1'($urandom_range(0, 1));
        s.mw   = 1'($urandom_range(0, 1));
        s.ordy = ($urandom_range(0, 2) != 0);
        s.fl   = ($urandom_range(0, 24) == 0);
        s.r    = ($urandom_range(0, 99) == 0);
        return s;
    endfunction

    // One cycle of stimulus, driven 1 time unit after the rising edge. The
    // scoreboard holds exactly the entries the buffer should contain.
    task automatic step(input stim_t s);
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(sb.size() > 0));
        if (!out_valid)
            chk("bubble_ctrl", 32'({out_reg_write, out_mem_read, out_mem_write, out_exc_ov}), 32'd0);
        rst          = s.r;
        flush        = s.fl;
        in_valid     = s.v;
        alu_y        = s.y;
        alu_zero     = s.z;
        alu_overflow = s.ov;
        write_data   = s.wd;
        wb_reg       = s.wr;
        reg_write    = s.rw;
        mem_read     = s.mr;
        mem_write    = s.mw;
        out_ready    = s.ordy;
        #1;
        if (s.r) begin
            sb.delete();
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_y", out_y, 32'd0);
            chk("rst_out_wd", out_write_data, 32'd0);
            chk("rst_out_misc", 32'({out_wb_reg, out_zero, out_reg_write, out_mem_read,
                                     out_mem_write, out_exc_ov}), 32'd0);
        end
        chk("in_ready", 32'(in_ready), 32'(!s.r && sb.size() < 2));
        if (s.v && !s.r && !s.fl && sb.size() < 2)
            sb.push_back(model(s));
    endtask

    // Monitor: on every MEM-side handshake the head must equal the oldest
    // outstanding entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_entry actual=out_y %h required=no entry at %0t", out_y, $time);
            end else begin
                e = sb.pop_front();
                chk("out_y", out_y, e.y);
                chk("out_zero", 32'(out_zero), 32'(e.z));
                chk("out_write_data", out_write_data, e.wd);
                chk("out_wb_reg", 32'(out_wb_reg), 32'(e.wr));
                chk("out_reg_write", 32'(out_reg_write), 32'(e.rw));
                chk("out_mem_read", 32'(out_mem_read), 32'(e.mr));
                chk("out_mem_write", 32'(out_mem_write), 32'(e.mw));
                chk("out_exc_ov", 32'(out_exc_ov), 32'(e.exc));
            end
        end
        if (!rst && flush)
            sb.delete();
    end

    initial begin
        stim_t s;
        rst          = 1'b1;
        flush        = 1'b0;
        in_valid     = 1'b0;
        alu_y        = '0;
        alu_zero     = 1'b0;
        alu_overflow = 1'b0;
        write_data   = '0;
        wb_reg       = '0;
        reg_write    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        out_ready    = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state and release.
        s = idle(1'b0); s.r = 1'b1; step(s);
        s = idle(1'b0); step(s);

        // Single-cycle latency and one-per-cycle streaming.
        for (int i = 0; i < 6; i++) begin
            s = idle(1'b1); s.v = 1'b1; s.y = 32'h10 + 32'(i); s.wr = 5'd5; s.rw = 1'b1;
            step(s);
        end
        repeat (2) step(idle(1'b1));

        // Back-pressure: A and B fill the buffer, C is held off until drained.
        s = idle(1'b0); s.v = 1'b1; s.y = 32'h1; step(s);
        s = idle(1'b0); s.v = 1'b1; s.y = 32'h2; step(s);
        s = idle(1'b0); s.v = 1'b1; s.y = 32'h3; step(s);
        s = idle(1'b0); s.v = 1'b1; s.y = 32'h3; step(s);
        s = idle(1'b1); s.v = 1'b1; s.y = 32'h3; step(s);
        s = idle(1'b1); s.v = 1'b1; s.y = 32'h3; step(s);
        repeat (3) step(idle(1'b1));

        // Flush with the buffer full and a valid input in the same cycle.
        s = idle(1'b0); s.v = 1'b1; s.y = 32'hA; step(s);
        s = idle(1'b0); s.v = 1'b1; s.y = 32'hB; step(s);
        s = idle(1'b0); s.v = 1'b1; s.y = 32'hDEAD; s.fl = 1'b1; step(s);
        repeat (2) step(idle(1'b1));

        // Reset while holding two entries.
        s = idle(1'b0); s.v = 1'b1; s.y = 32'h55; s.rw = 1'b1; step(s);
        s = idle(1'b0); s.v = 1'b1; s.y = 32'h66; s.mw = 1'b1; step(s);
        s = idle(1'b0); s.r = 1'b1; step(s);
        step(idle(1'b1));

        // Overflowing instruction with writeback and store enables.
        s = idle(1'b1); s.v = 1'b1; s.y = 32'h8000_0000; s.ov = 1'b1;
        s.rw = 1'b1; s.mw = 1'b1; s.wr = 5'd9;
        step(s);
        repeat (2) step(idle(1'b1));

        // Random traffic.
        for (int i = 0; i < 3000; i++)
            step(rand_stim());

        // Drain; the buffer holds at most two entries.
        repeat (4) step(idle(1'b1));
        @(negedge clk);
        #1;
        chk("drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
